// File: rtl/volume_ctrl_if.sv
// Button/level bundle for volume_ctrl: per-channel up/down buttons in, pulses and packed levels out.
// The controller takes the slave modport and the button driver takes the master modport.
interface volume_ctrl_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned W   = 4
);
  logic [NCH-1:0]   up;
  logic [NCH-1:0]   down;
  logic [NCH-1:0]   increment;
  logic [NCH-1:0]   decrement;
  logic [NCH*W-1:0] level;

  modport master (
    output up, down,
    input  increment, decrement, level
  );

  modport slave (
    input  up, down,
    output increment, decrement, level
  );
endinterface

// File: rtl/volume_ctrl.sv
// Multi-channel saturating volume controller with press/hold FSM per channel.
// Define VOLUME_REPEAT_EN to compile in auto-repeat (HOLD/RATE counter); otherwise one step per press.
module volume_ctrl #(
  parameter int unsigned NCH  = 2,
  parameter int unsigned W    = 4,
  parameter int unsigned INIT = 8,
  parameter int unsigned HOLD = 4,
  parameter int unsigned RATE = 2
) (
  input logic         clk,
  input logic         reset,
  volume_ctrl_if.slave bus
);

  if (NCH < 1 || W < 2 || INIT > (2 ** W) - 1 || HOLD < 1 || RATE < 1) begin : g_bad_param
    $error("volume_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    StIdle,
    StUpPress,
    StUpHeld,
    StDnPress,
    StDnHeld
  } state_e;

  localparam logic [W-1:0] Max = {W{1'b1}};

  state_e         state_q [NCH];
  state_e         state_d [NCH];
  logic [W-1:0]   level_q [NCH];
  logic [W-1:0]   level_d [NCH];
  logic [NCH-1:0] inc;
  logic [NCH-1:0] dec;
  logic [NCH*W-1:0] level_packed;

`ifdef VOLUME_REPEAT_EN
  localparam int unsigned CntW = $clog2((HOLD > RATE ? HOLD : RATE) + 1);

  logic [CntW-1:0] cnt_q [NCH];
  logic [CntW-1:0] cnt_d [NCH];
  // Set while a PRESS was entered from HELD, selecting the shorter RATE reload.
  logic            rpt_q [NCH];
  logic            rpt_d [NCH];
`endif

  always_comb begin
    inc          = '0;
    dec          = '0;
    level_packed = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      level_d[i] = level_q[i];
`ifdef VOLUME_REPEAT_EN
      cnt_d[i]   = cnt_q[i];
      rpt_d[i]   = rpt_q[i];
`endif
      inc[i] = (state_q[i] == StUpPress) && (level_q[i] != Max);
      dec[i] = (state_q[i] == StDnPress) && (level_q[i] != '0);
      if (inc[i]) begin
        level_d[i] = level_q[i] + W'(1);
      end else if (dec[i]) begin
        level_d[i] = level_q[i] - W'(1);
      end
      level_packed[i*W +: W] = level_q[i];

      unique case (state_q[i])
        StIdle: begin
`ifdef VOLUME_REPEAT_EN
          rpt_d[i] = 1'b0;
`endif
          if (bus.up[i] && !bus.down[i]) begin
            state_d[i] = StUpPress;
          end else if (bus.down[i] && !bus.up[i]) begin
            state_d[i] = StDnPress;
          end
        end
        StUpPress: begin
          state_d[i] = StUpHeld;
`ifdef VOLUME_REPEAT_EN
          cnt_d[i]   = rpt_q[i] ? CntW'(RATE - 1) : CntW'(HOLD - 1);
`endif
        end
        StUpHeld: begin
          if (!bus.up[i]) begin
            state_d[i] = StIdle;
`ifdef VOLUME_REPEAT_EN
          end else if (cnt_q[i] == '0) begin
            state_d[i] = StUpPress;
            rpt_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
`endif
          end
        end
        StDnPress: begin
          state_d[i] = StDnHeld;
`ifdef VOLUME_REPEAT_EN
          cnt_d[i]   = rpt_q[i] ? CntW'(RATE - 1) : CntW'(HOLD - 1);
`endif
        end
        StDnHeld: begin
          if (!bus.down[i]) begin
            state_d[i] = StIdle;
`ifdef VOLUME_REPEAT_EN
          end else if (cnt_q[i] == '0) begin
            state_d[i] = StDnPress;
            rpt_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
`endif
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= StIdle;
        level_q[i] <= W'(INIT);
`ifdef VOLUME_REPEAT_EN
        cnt_q[i]   <= '0;
        rpt_q[i]   <= 1'b0;
`endif
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        level_q[i] <= level_d[i];
`ifdef VOLUME_REPEAT_EN
        cnt_q[i]   <= cnt_d[i];
        rpt_q[i]   <= rpt_d[i];
`endif
      end
    end
  end

  assign bus.increment = inc;
  assign bus.decrement = dec;
  assign bus.level     = level_packed;

endmodule
